// File: rtl/elev_pkg.sv
// Shared types and constants for the lift door controller.
//   door_state_t : door FSM state, also driven out on door_state
//   NUM_FLOORS   : width of the one-hot floor buses
package elev_pkg;

    localparam int NUM_FLOORS = 4;

    typedef enum logic [1:0] {
        CLOSED  = 2'd0,
        OPENING = 2'd1,
        OPEN    = 2'd2,
        CLOSING = 2'd3
    } door_state_t;

endpackage

// File: rtl/door_ctrl_if.sv
// Signal bundle between the lift controller and the door controller.
//   master : lift side  - drives stop_req, floor_onehot, buttons, obstruct
//   slave  : door side  - drives motion_en, door_state, door_open,
//                         served_pulse, fault
interface door_ctrl_if;
    import elev_pkg::*;

    logic                  stop_req;
    logic [NUM_FLOORS-1:0] floor_onehot;
    logic                  door_open_btn;
    logic                  door_close_btn;
    logic                  obstruct;
    logic                  motion_en;
    door_state_t           door_state;
    logic                  door_open;
    logic [NUM_FLOORS-1:0] served_pulse;
    logic                  fault;

    modport master (
        output stop_req, floor_onehot, door_open_btn, door_close_btn, obstruct,
        input  motion_en, door_state, door_open, served_pulse, fault
    );

    modport slave (
        input  stop_req, floor_onehot, door_open_btn, door_close_btn, obstruct,
        output motion_en, door_state, door_open, served_pulse, fault
    );

endinterface

// File: rtl/door_timer.sv
// Loadable down-counter used to time the OPENING/OPEN/CLOSING phases.
//   clk, rst  : clock, synchronous active-low reset
//   load      : load load_val this cycle (wins over counting)
//   load_val  : value to load; a phase of N cycles loads N-1
//   done      : count has reached zero
// The counter holds at zero instead of wrapping.
module door_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/door_ctrl.sv
// Lift door controller: opens the door when the car stops at a floor,
// holds it open for a dwell time, closes it, and reopens on obstruction
// or the open button. Too many reopens in one stop latch a fault that
// keeps the door open until reset.
//   clk, rst : clock, synchronous active-low reset
//   bus      : door_ctrl_if.slave (inputs from the lift, registered outputs)
module door_ctrl
    import elev_pkg::*;
#(
    parameter int OPEN_CYCLES  = 4,
    parameter int DWELL_CYCLES = 10,
    parameter int CLOSE_CYCLES = 4,
    parameter int MAX_REOPEN   = 3
) (
    input  logic        clk,
    input  logic        rst,
    door_ctrl_if.slave  bus
);

    localparam int MAX_OD  = (OPEN_CYCLES > DWELL_CYCLES) ? OPEN_CYCLES : DWELL_CYCLES;
    localparam int MAX_CYC = (MAX_OD > CLOSE_CYCLES) ? MAX_OD : CLOSE_CYCLES;
    localparam int TW      = $clog2(MAX_CYC) + 1;
    localparam int RW      = $clog2(MAX_REOPEN + 1) + 1;

    localparam logic [TW-1:0] OPEN_LD  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0] DWELL_LD = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] CLOSE_LD = TW'(CLOSE_CYCLES - 1);
    localparam logic [RW-1:0] REOPEN_MAX = RW'(MAX_REOPEN);

    door_state_t           state, state_n;
    logic [RW-1:0]         reopen_cnt, reopen_cnt_n;
    logic [NUM_FLOORS-1:0] floor_lat, floor_lat_n;
    logic                  fault_q, fault_n;
    logic                  prev_stop, stop_low_seen;
    logic                  motion_q, open_q;
    logic [NUM_FLOORS-1:0] served_q;

    logic                  tmr_load;
    logic [TW-1:0]         tmr_val;
    logic                  tmr_done;

    logic                  stop_rise, floor_ok, reopen_req;

    // A rise only counts once stop_req has been seen low since reset, so a
    // stop_req still held high across a reset does not reopen the door.
    assign stop_rise  = bus.stop_req & ~prev_stop & stop_low_seen;
    assign floor_ok   = $onehot(bus.floor_onehot);
    // obstruct and the open button both outrank the close button
    assign reopen_req = bus.obstruct | bus.door_open_btn;

    door_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_comb begin
        state_n      = state;
        reopen_cnt_n = reopen_cnt;
        floor_lat_n  = floor_lat;
        fault_n      = fault_q;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        unique case (state)
            CLOSED: begin
                if (floor_ok && (stop_rise || (bus.door_open_btn && bus.stop_req))) begin
                    state_n     = OPENING;
                    floor_lat_n = bus.floor_onehot;
                    tmr_load    = 1'b1;
                    tmr_val     = OPEN_LD;
                end
            end
            OPENING: begin
                if (tmr_done) begin
                    state_n  = OPEN;
                    tmr_load = 1'b1;
                    tmr_val  = DWELL_LD;
                end
            end
            OPEN: begin
                // a faulted door stays open until reset
                if (!fault_q) begin
                    if (reopen_req) begin
                        tmr_load = 1'b1;
                        tmr_val  = DWELL_LD;
                    end else if (bus.door_close_btn || tmr_done) begin
                        state_n  = CLOSING;
                        tmr_load = 1'b1;
                        tmr_val  = CLOSE_LD;
                    end
                end
            end
            CLOSING: begin
                if (reopen_req) begin
                    state_n  = OPENING;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LD;
                    if (reopen_cnt == REOPEN_MAX)
                        fault_n = 1'b1;
                    else
                        reopen_cnt_n = reopen_cnt + RW'(1);
                end else if (tmr_done) begin
                    state_n      = CLOSED;
                    reopen_cnt_n = '0;
                    floor_lat_n  = '0;
                end
            end
            default: state_n = CLOSED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= CLOSED;
            reopen_cnt    <= '0;
            floor_lat     <= '0;
            fault_q       <= 1'b0;
            prev_stop     <= 1'b0;
            stop_low_seen <= 1'b0;
            motion_q      <= 1'b1;
            open_q        <= 1'b0;
            served_q      <= '0;
        end else begin
            state         <= state_n;
            reopen_cnt    <= reopen_cnt_n;
            floor_lat     <= floor_lat_n;
            fault_q       <= fault_n;
            prev_stop     <= bus.stop_req;
            stop_low_seen <= stop_low_seen | ~bus.stop_req;
            motion_q      <= (state_n == CLOSED) && !fault_n;
            open_q        <= (state_n == OPEN);
            // reopens (count > 0) and the fault path re-enter OPEN silently
            served_q      <= (state == OPENING && state_n == OPEN &&
                              reopen_cnt == '0 && !fault_q) ? floor_lat : '0;
        end
    end

    assign bus.door_state   = state;
    assign bus.motion_en    = motion_q;
    assign bus.door_open    = open_q;
    assign bus.served_pulse = served_q;
    assign bus.fault        = fault_q;

endmodule

// File: tb/tb_door_ctrl.sv
// Self-checking bench for door_ctrl: a vector table, directed multi-cycle
// sequences, and a randomized run against a phase/age reference model.
module tb_door_ctrl;
    import elev_pkg::*;

    localparam int OC = 4;
    localparam int DC = 10;
    localparam int CC = 4;
    localparam int MR = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    door_ctrl_if bus();

    door_ctrl #(
        .OPEN_CYCLES  (OC),
        .DWELL_CYCLES (DC),
        .CLOSE_CYCLES (CC),
        .MAX_REOPEN   (MR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic [3:0] f, input bit ob, input bit cb, input bit obs);
        bus.stop_req       = s;
        bus.floor_onehot   = f;
        bus.door_open_btn  = ob;
        bus.door_close_btn = cb;
        bus.obstruct       = obs;
    endtask

    task automatic reset_idle();
        rst = 1'b0;
        drive(0, 4'b0000, 0, 0, 0);
        tick();
        chk("reset_state", bus.door_state, CLOSED);
        rst = 1'b1;
        tick();
        tick();
    endtask

    task automatic wait_state(input door_state_t tgt, input int budget);
        int n = 0;
        while (bus.door_state !== tgt && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", bus.door_state, tgt);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          r, s;
        logic [3:0]  f;
        bit          ob, cb, obs;
        door_state_t st;
        bit          mot, dop;
        logic [3:0]  srv;
        bit          flt;
    } vec_t;

    vec_t tbl[11];

    // ---------------- reference model ----------------
    // Phase plus "cycles already spent" in it; outputs are what the
    // registered outputs must show after the clock edge.
    int         m_phase, m_age, m_reopens;
    bit         m_fault, m_prev, m_low;
    logic [3:0] m_floor;
    int         e_st;
    bit         e_mot, e_open, e_flt;
    logic [3:0] e_srv;

    function automatic void m_step(bit r, bit s, logic [3:0] f, bit ob, bit cb, bit obs);
        bit rise, hot, req;
        e_srv = 4'b0000;
        if (!r) begin
            m_phase = 0; m_age = 0; m_reopens = 0; m_fault = 0;
            m_prev = 0; m_low = 0; m_floor = 4'b0000;
            e_st = 0; e_mot = 1; e_open = 0; e_flt = 0;
            return;
        end
        rise  = s && !m_prev && m_low;
        hot   = ($countones(f) == 1);
        req   = obs || ob;
        m_low = m_low || !s;
        m_prev = s;
        case (m_phase)
            0: if (hot && (rise || (ob && s))) begin
                m_phase = 1; m_age = 0; m_floor = f;
            end
            1: if (m_age + 1 >= OC) begin
                m_phase = 2; m_age = 0;
                if (m_reopens == 0 && !m_fault) e_srv = m_floor;
            end else m_age++;
            2: if (!m_fault) begin
                if (req) m_age = 0;
                else if (cb || m_age + 1 >= DC) begin m_phase = 3; m_age = 0; end
                else m_age++;
            end
            default: if (req) begin
                if (m_reopens >= MR) m_fault = 1; else m_reopens++;
                m_phase = 1; m_age = 0;
            end else if (m_age + 1 >= CC) begin
                m_phase = 0; m_reopens = 0; m_floor = 4'b0000;
            end else m_age++;
        endcase
        e_st   = m_phase;
        e_mot  = (m_phase == 0) && !m_fault;
        e_open = (m_phase == 2);
        e_flt  = m_fault;
    endfunction

    // expected state for a stop at cycle 0, optionally obstructed at cycle 16
    function automatic door_state_t exp_stop(int c, bit reopen);
        if (c < 1)  return CLOSED;
        if (c < 5)  return OPENING;
        if (c < 15) return OPEN;
        if (!reopen) return (c < 19) ? CLOSING : CLOSED;
        if (c < 17) return CLOSING;
        if (c < 21) return OPENING;
        if (c < 31) return OPEN;
        if (c < 35) return CLOSING;
        return CLOSED;
    endfunction

    initial begin
        bit         rs, ss, ob, cb, obs;
        logic [3:0] fl;
        drive(0, 4'b0000, 0, 0, 0);

        // rows: inputs applied for one edge, then registered outputs checked
        tbl[0]  = '{0, 0, 4'b0000, 0, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[1]  = '{0, 1, 4'b0100, 1, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[2]  = '{1, 0, 4'b0100, 0, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[3]  = '{1, 1, 4'b0110, 0, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[4]  = '{1, 1, 4'b0110, 1, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[5]  = '{1, 0, 4'b0000, 0, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[6]  = '{1, 1, 4'b0000, 0, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[7]  = '{1, 0, 4'b0010, 0, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        tbl[8]  = '{1, 1, 4'b0001, 0, 0, 0, OPENING, 0, 0, 4'b0000, 0};
        tbl[9]  = '{1, 0, 4'b1000, 0, 1, 0, OPENING, 0, 0, 4'b0000, 0};
        tbl[10] = '{0, 0, 4'b0000, 0, 0, 0, CLOSED,  1, 0, 4'b0000, 0};
        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].r;
            drive(tbl[i].s, tbl[i].f, tbl[i].ob, tbl[i].cb, tbl[i].obs);
            tick();
            chk($sformatf("tbl%0d_state", i),  bus.door_state,   tbl[i].st);
            chk($sformatf("tbl%0d_motion", i), bus.motion_en,    tbl[i].mot);
            chk($sformatf("tbl%0d_open", i),   bus.door_open,    tbl[i].dop);
            chk($sformatf("tbl%0d_served", i), bus.served_pulse, tbl[i].srv);
            chk($sformatf("tbl%0d_fault", i),  bus.fault,        tbl[i].flt);
        end

        // basic stop, then a stop obstructed once during CLOSING
        for (int pass = 0; pass < 2; pass++) begin
            reset_idle();
            for (int c = 0; c < 38; c++) begin
                drive(1, 4'b0100, 0, 0, (pass == 1) && (c == 16));
                chk($sformatf("stop%0d_state_c%0d", pass, c), bus.door_state, exp_stop(c, pass == 1));
                chk($sformatf("stop%0d_served_c%0d", pass, c), bus.served_pulse,
                    (c == 5) ? 4'b0100 : 4'b0000);
                chk($sformatf("stop%0d_motion_c%0d", pass, c), bus.motion_en,
                    exp_stop(c, pass == 1) == CLOSED);
                chk($sformatf("stop%0d_open_c%0d", pass, c), bus.door_open,
                    exp_stop(c, pass == 1) == OPEN);
                tick();
            end
        end

        // close button from cycle 6 closes early
        reset_idle();
        for (int c = 0; c < 13; c++) begin
            drive(1, 4'b0010, 0, c >= 6, 0);
            chk($sformatf("cbtn_state_c%0d", c), bus.door_state,
                (c < 1) ? CLOSED : (c < 5) ? OPENING : (c < 7) ? OPEN : (c < 11) ? CLOSING : CLOSED);
            tick();
        end

        // close button held with obstruct held: obstruct wins until released
        reset_idle();
        for (int c = 0; c < 34; c++) begin
            drive(1, 4'b0010, 0, c >= 6, (c >= 6) && (c <= 30));
            chk($sformatf("cbtn_obs_state_c%0d", c), bus.door_state,
                (c < 1) ? CLOSED : (c < 5) ? OPENING : (c < 32) ? OPEN : CLOSING);
            tick();
        end

        // reset in OPEN; held stop_req must re-rise before reopening
        reset_idle();
        for (int c = 0; c < 29; c++) begin
            rst = (c != 8);
            drive(c != 26, 4'b1000, 0, 0, 0);
            if (c == 8 || c == 9 || c == 20 || c == 27 || c == 28)
                chk($sformatf("rst_state_c%0d", c), bus.door_state,
                    (c == 8) ? OPEN : (c == 28) ? OPENING : CLOSED);
            if (c == 9) begin
                chk("rst_motion", bus.motion_en, 1);
                chk("rst_fault",  bus.fault, 0);
                chk("rst_open",   bus.door_open, 0);
            end
            tick();
        end
        rst = 1'b1;

        // reopen limit: fourth reopen faults, door then stays open
        reset_idle();
        drive(1, 4'b0001, 0, 0, 0);
        tick();
        for (int k = 1; k <= 4; k++) begin
            wait_state(CLOSING, 40);
            bus.obstruct = 1'b1;
            tick();
            bus.obstruct = 1'b0;
            chk($sformatf("reopen%0d_state", k), bus.door_state, OPENING);
            chk($sformatf("reopen%0d_fault", k), bus.fault, k == 4);
            chk($sformatf("reopen%0d_served", k), bus.served_pulse, 0);
        end
        wait_state(OPEN, 20);
        bus.door_close_btn = 1'b1;
        for (int i = 0; i < 120; i++) begin
            chk("fault_hold_open",   bus.door_open, 1);
            chk("fault_hold_motion", bus.motion_en, 0);
            tick();
        end
        bus.door_close_btn = 1'b0;
        chk("fault_sticky", bus.fault, 1);
        chk("fault_state",  bus.door_state, OPEN);

        // randomized run against the reference model
        ss = 0;
        fl = 4'b0001;
        for (int i = 0; i < 4000; i++) begin
            rs = !((i == 0) || ($urandom_range(0, 199) == 0));
            if ($urandom_range(0, 14) == 0) ss = !ss;
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 6) != 0) fl = 4'(1) << $urandom_range(0, 3);
                else fl = 4'($urandom);
            end
            ob  = ($urandom_range(0, 29) == 0);
            cb  = ($urandom_range(0, 19) == 0);
            obs = ($urandom_range(0, 11) == 0);
            rst = rs;
            drive(ss, fl, ob, cb, obs);
            m_step(rs, ss, fl, ob, cb, obs);
            tick();
            chk($sformatf("rand_c%0d {state,motion,open,served,fault}", i),
                {bus.door_state, bus.motion_en, bus.door_open, bus.served_pulse, bus.fault},
                {2'(e_st), e_mot, e_open, e_srv, e_flt});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/door_ctrl.md
DOOR_CTRL -- requirements
Module: door_ctrl

Interface
REQ-001 SHALL have parameter OPEN_CYCLES, default 4, the number of cycles the door spends opening.
REQ-002 SHALL have parameter DWELL_CYCLES, default 10, the number of cycles the door is held fully open.
REQ-003 SHALL have parameter CLOSE_CYCLES, default 4, the number of cycles the door spends closing.
REQ-004 SHALL have parameter MAX_REOPEN, default 3, the number of reopens per stop before fault.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, reset; it is synchronous and active-low.
REQ-007 SHALL have port stop_req, input, 1 bit, the lift controller's "stopped at floor" indication.
REQ-008 SHALL have port floor_onehot, input, 4 bits, the current floor {out_three, out_two, out_one, out_gnd}.
REQ-009 SHALL have port door_open_btn, input, 1 bit, the cabin open button, level.
REQ-010 SHALL have port door_close_btn, input, 1 bit, the cabin close button, level.
REQ-011 SHALL have port obstruct, input, 1 bit, the door-edge sensor, level.
REQ-012 SHALL have port motion_en, output, 1 bit; the lift controller may move only while it is 1.
REQ-013 SHALL have port door_state, output, 2 bits, the current door_state_t state.
REQ-014 SHALL have port door_open, output, 1 bit, 1 only while the door is fully open.
REQ-015 SHALL have port served_pulse, output, 4 bits, a one-cycle one-hot pulse for the floor served.
REQ-016 SHALL have port fault, output, 1 bit, sticky; set when the reopen limit is exceeded.

Function
REQ-017 SHALL implement FSM states CLOSED, OPENING, OPEN and CLOSING, with all outputs registered.
REQ-018 CLOSED: SHALL go to OPENING when a stop_req rising edge is seen (registered previous value) and floor_onehot is exactly one-hot.
REQ-019 CLOSED: SHALL also go to OPENING on door_open_btn while stop_req=1 and floor_onehot is one-hot.
REQ-020 CLOSED: SHALL ignore a non-one-hot floor_onehot and stay CLOSED.
REQ-021 SHALL latch floor_onehot on entry to OPENING; later changes to floor_onehot are ignored until the next return to CLOSED.
REQ-022 motion_en SHALL be 1 only in CLOSED with fault=0; it falls in the same cycle that door_state becomes OPENING.
REQ-023 Each timed state (OPENING, OPEN, CLOSING) SHALL last exactly its parameter count of cycles, and a new count SHALL be loaded on every state entry.
REQ-024 On entry to OPEN, served_pulse SHALL equal the latched floor for exactly one cycle; a reopen that re-enters OPEN SHALL NOT pulse again.
REQ-025 OPEN: obstruct or door_open_btn SHALL reload the dwell count to DWELL_CYCLES.
REQ-026 OPEN: door_close_btn with no obstruct and no door_open_btn SHALL go to CLOSING next cycle.
REQ-027 Priority SHALL be obstruct > door_open_btn > door_close_btn.
REQ-028 OPEN: SHALL go to CLOSING when the dwell count expires.
REQ-029 CLOSING: obstruct or door_open_btn SHALL go to OPENING with a full OPEN_CYCLES count and increment reopen_cnt.
REQ-030 CLOSING: when the count completes, SHALL go to CLOSED and clear reopen_cnt.
REQ-031 If a reopen is requested while reopen_cnt==MAX_REOPEN, fault SHALL set and the door SHALL go to OPENING then OPEN.
REQ-032 With fault=1 the door SHALL stay in OPEN indefinitely; no auto-close, close button ignored, until reset.
REQ-033 Timer width SHALL be $clog2 of max(OPEN_CYCLES, DWELL_CYCLES, CLOSE_CYCLES) plus 1; the counter SHALL never wrap.
REQ-034 reopen_cnt SHALL saturate and SHALL NOT wrap.
REQ-035 stop_req falling while not CLOSED SHALL NOT abort the sequence; the sequence always completes to CLOSED.

Reset
REQ-036 rst=0 at a clock edge SHALL force CLOSED, timer=0, reopen_cnt=0, latched floor=0 and prev stop_req=0.
REQ-037 Reset output values SHALL be motion_en=1, door_open=0, served_pulse=0, fault=0, door_state=CLOSED; this holds for reset mid-operation too.

Structure
REQ-038 Package elev_pkg SHALL hold door_state_t (CLOSED=0, OPENING=1, OPEN=2, CLOSING=3) and NUM_FLOORS=4.
REQ-039 The block SHALL use one sub-module, door_timer: a loadable down-counter with a done flag, instantiated once.

Verification (defaults; cycle 0 = first cycle stop_req=1 with floor_onehot=0100)
REQ-040 Basic stop -> OPENING at 1, OPEN at 5 with served_pulse=0100 at 5, CLOSING at 15, CLOSED with motion_en=1 at 19.
REQ-041 Obstruct during CLOSING at cycle 16 -> OPENING at 17, OPEN at 21, no second served_pulse, reopen_cnt=1.
REQ-042 Four reopens in one stop -> fault=1 after the 4th request, door_open=1 held for 100+ cycles, motion_en=0.
REQ-043 door_close_btn held from cycle 6 -> CLOSING at 7; the same with obstruct=1 also held -> stays OPEN.
REQ-044 floor_onehot=0110 with stop_req rising -> stays CLOSED, motion_en=1, served_pulse=0.
REQ-045 rst=0 at cycle 8 (OPEN) -> next cycle door_state=CLOSED, motion_en=1, fault=0; stop_req held at 1 does not reopen until it re-rises.
